// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the memory-port byte-order helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  // The memory port is big-endian within a word; the core side is little-endian.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: extracts and extends load data from a
// little-endian word and merges store data into it for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] lw,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = lw[{addr_lo, 3'b000} +: 8];
    lane_half = addr_lo[1] ? lw[31:16] : lw[15:0];
    case (size)
      SZ_BYTE: load_data = {{24{sgn & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_data = {{16{sgn & lane_half[15]}}, lane_half};
      default: load_data = lw;
    endcase
  end

  // Each byte lane either keeps the old memory byte or takes a store byte.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       hit;
      logic [7:0] src;

      assign hit = (size == SZ_BYTE) ? (addr_lo == LANE) :
                   (size == SZ_HALF) ? (addr_lo[1] == LANE[1]) : 1'b1;
      assign src = (size == SZ_BYTE) ? wdata[7:0] :
                   (size == SZ_HALF) ? (LANE[0] ? wdata[15:8] : wdata[7:0]) :
                   wdata[8*gi +: 8];
      assign store_word[8*gi +: 8] = hit ? src : lw[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/lsu.sv
// Load/store unit: request/response handshake, alignment checking and
// read-modify-write of sub-word stores against a 32-bit data memory port.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  state_t      state_reg, state_next;
  logic        we_reg, sgn_reg, err_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg, wdata_reg, lw_reg, rdata_reg;

  logic        accept, req_bad;
  logic [31:0] lw_rd, align_lw, load_data, store_word;

  assign accept   = req_valid && (state_reg == ST_IDLE);
  assign req_bad  = bad_access(req_size, req_addr[1:0]);
  assign lw_rd    = bswap32(mem_rd);
  // Loads extract straight from the memory word in RD; stores merge from the captured copy in WR.
  assign align_lw = (state_reg == ST_RD) ? lw_rd : lw_reg;

  lsu_align u_align (
    .lw         (align_lw),
    .addr_lo    (addr_reg[1:0]),
    .size       (size_reg),
    .sgn        (sgn_reg),
    .wdata      (wdata_reg),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'd0;
    mem_wd     = 32'd0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)                              state_next = ST_RESP;
          else if (!req_we || req_size != SZ_WORD)  state_next = ST_RD;
          else                                      state_next = ST_WR;
        end
      end
      ST_RD: begin
        mem_addr   = {addr_reg[31:2], 2'b00};
        state_next = we_reg ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        mem_addr   = {addr_reg[31:2], 2'b00};
        mem_wd     = store_word;
        mem_we     = !rst;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg    <= 1'b0;
      sgn_reg   <= 1'b0;
      err_reg   <= 1'b0;
      size_reg  <= SZ_BYTE;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      lw_reg    <= 32'd0;
      rdata_reg <= 32'd0;
    end else begin
      if (accept) begin
        we_reg    <= req_we;
        sgn_reg   <= req_signed;
        err_reg   <= req_bad;
        size_reg  <= req_size;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        rdata_reg <= 32'd0;
      end
      if (state_reg == ST_RD) begin
        lw_reg <= lw_rd;
        if (!we_reg) rdata_reg <= load_data;
      end
    end
  end

  assign resp_rdata = resp_valid ? rdata_reg : 32'd0;
  assign resp_err   = resp_valid ? err_reg : 1'b0;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-addressed memory model plus directed and
// randomized transactions checked against a byte-level reference.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd)
  );

  // Data memory seen by the DUT (big-endian read port, per-byte write mapping).
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       mem_init;
  logic [7:0] ma;

  assign ma     = mem_addr[7:0];
  assign mem_rd = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (mem_we) begin
      mem[ma]        <= mem_wd[7:0];
      mem[ma + 8'd1] <= mem_wd[15:8];
      mem[ma + 8'd2] <= mem_wd[23:16];
      mem[ma + 8'd3] <= mem_wd[31:24];
    end
  end

  // Reference: memory is a plain byte array, accesses are n = 2**size bytes, little-endian.
  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    int n;
    if (sz == 2'd3) return 1'b1;
    n = 1 << sz;
    return (a % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sgn,
                                             input logic [31:0] a);
    int n;
    logic [31:0] v;
    logic [7:0] idx;
    n = 1 << sz;
    v = 32'd0;
    for (int i = 0; i < n; i++) begin
      idx = a[7:0] + 8'(i);
      v = v | (32'(ref_mem[idx]) << (8 * i));
    end
    if (sgn && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int n;
    logic [7:0] idx;
    n = 1 << sz;
    for (int i = 0; i < n; i++) begin
      idx = a[7:0] + 8'(i);
      ref_mem[idx] = 8'(d >> (8 * i));
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall, input string name, output logic [31:0] got);
    logic        exp_err;
    logic [31:0] exp_rdata, hold_rdata;
    logic        hold_err;
    int          exp_lat, exp_we_lat, lat, we_cnt, we_lat;
    exp_err = model_err(sz, addr);
    exp_rdata = 32'd0;
    exp_we_lat = -1;
    if (exp_err) exp_lat = 1;
    else if (!we) begin exp_lat = 2; exp_rdata = model_load(sz, sgn, addr); end
    else if (sz == 2'd2) begin exp_lat = 2; exp_we_lat = 1; model_store(sz, addr, wdata); end
    else begin exp_lat = 3; exp_we_lat = 2; model_store(sz, addr, wdata); end

    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL %s idle_ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
    req_addr = $urandom; req_wdata = $urandom;

    lat = 1; we_cnt = 0; we_lat = -1;
    while (lat < 20) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++; we_lat = lat;
        total++;
        if (mem_addr !== {addr[31:2], 2'b00}) begin
          bad++; $display("FAIL %s mem_addr: got %h want %h", name, mem_addr, {addr[31:2], 2'b00});
        end
      end
      if (resp_valid === 1'b1) break;
      total++;
      if (req_ready !== 1'b0) begin
        bad++; $display("FAIL %s busy_ready: got %b want 0", name, req_ready);
      end
      @(posedge clk);
      lat++;
    end

    total++;
    if (lat !== exp_lat) begin
      bad++; $display("FAIL %s latency: got T+%0d want T+%0d", name, lat, exp_lat);
    end
    total++;
    if (resp_err !== exp_err || resp_rdata !== exp_rdata) begin
      bad++; $display("FAIL %s resp: got err=%b rdata=%h want err=%b rdata=%h",
                      name, resp_err, resp_rdata, exp_err, exp_rdata);
    end
    total++;
    if (we_cnt !== (exp_we_lat >= 0 ? 1 : 0) || we_lat !== exp_we_lat) begin
      bad++; $display("FAIL %s mem_we: got %0d pulses at T+%0d want %0d at T+%0d",
                      name, we_cnt, we_lat, (exp_we_lat >= 0 ? 1 : 0), exp_we_lat);
    end
    got = resp_rdata;
    hold_rdata = resp_rdata;
    hold_err = resp_err;

    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== hold_rdata || resp_err !== hold_err ||
          req_ready !== 1'b0) begin
        bad++; $display("FAIL %s stall_cycle%0d: got valid=%b rdata=%h err=%b ready=%b want 1 %h %b 0",
                        name, k, resp_valid, resp_rdata, resp_err, req_ready, hold_rdata, hold_err);
      end
    end

    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL %s release: got valid=%b ready=%b want 0 1", name, resp_valid, req_ready);
    end
    $display("txn %-10s we=%0d sz=%0d sgn=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             name, we, sz, sgn, addr, wdata, got, hold_err, lat);
  endtask

  task automatic check_mem(input string name);
    int diffs;
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    total++;
    if (diffs != 0) begin
      bad++; $display("FAIL %s memory: got %0d differing bytes want 0", name, diffs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_init = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 ||
        mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wd !== 32'd0) begin
      bad++; $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b we=%b addr=%h wd=%h",
                      req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd);
    end
    rst = 1'b0; mem_init = 1'b0;
    $display("txn reset");
  endtask

  task automatic test_loads();
    logic [31:0] g;
    do_req(1'b0, 2'd2, 1'b1, 32'h10, 32'd0, 0, "ld_w", g);
    total++; if (g !== 32'h84332211) begin bad++; $display("FAIL ld_w_const: got %h want 84332211", g); end
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 0, "ld_bs", g);
    total++; if (g !== 32'hFFFFFF84) begin bad++; $display("FAIL ld_bs_const: got %h want ffffff84", g); end
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 0, "ld_bu", g);
    total++; if (g !== 32'h00000084) begin bad++; $display("FAIL ld_bu_const: got %h want 00000084", g); end
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, 0, "ld_hs", g);
    total++; if (g !== 32'hFFFF8433) begin bad++; $display("FAIL ld_hs_const: got %h want ffff8433", g); end
  endtask

  task automatic test_byte_store();
    logic [31:0] g;
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h5555_55AB, 0, "st_b", g);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, "ld_after", g);
    total++; if (g !== 32'h8433AB11) begin bad++; $display("FAIL st_b_merge: got %h want 8433ab11", g); end
  endtask

  task automatic test_errors();
    logic [31:0] g;
    do_req(1'b0, 2'd1, 1'b1, 32'h11, 32'd0, 0, "err_ld_h", g);
    do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'hDEADBEEF, 0, "err_st_w", g);
    do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'hCAFEF00D, 0, "err_rsvd", g);
    check_mem("errors");
  endtask

  task automatic test_stall();
    logic [31:0] g;
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5, "stall_ld", g);
  endtask

  task automatic test_reset_in_wr();
    logic [31:0] g;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'h22; req_wdata = 32'h0000_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h20) begin
      bad++; $display("FAIL rst_wr_strobe: got we=%b addr=%h want 0 00000020", mem_we, mem_addr);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 ||
        mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wd !== 32'd0) begin
      bad++; $display("FAIL rst_wr_outputs: got ready=%b valid=%b rdata=%h err=%b we=%b addr=%h wd=%h",
                      req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wd);
    end
    $display("txn rst_in_wr addr=00000022");
    check_mem("rst_in_wr");
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, "ld_rst_chk", g);
  endtask

  task automatic test_random(input int count);
    logic [31:0] g, a, d;
    logic [1:0]  sz;
    logic        we, sgn;
    for (int i = 0; i < count; i++) begin
      we  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      d   = $urandom;
      do_req(we, sz, sgn, a, d, $urandom_range(0, 2), "rand", g);
    end
    check_mem("random");
  endtask

  task automatic test_back_to_back();
    logic [31:0] g;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b1, 2'd1, 1'b0, 32'h40 + 32'(2 * i), $urandom, 0, "b2b_st", g);
      do_req(1'b0, 2'(i % 3), 1'(i % 2), 32'h40 + 32'(i & 32'hC), 32'd0, 0, "b2b_ld", g);
    end
    check_mem("back_to_back");
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    rst = 1'b1; mem_init = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    ref_mem[8'h10] = 8'h11; ref_mem[8'h11] = 8'h22;
    ref_mem[8'h12] = 8'h33; ref_mem[8'h13] = 8'h84;

    test_reset();
    test_loads();
    test_byte_store();
    test_errors();
    test_stall();
    test_reset_in_wr();
    test_random(60);
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the core's memory-stage and the byte-array data memory. It accepts byte, halfword and word loads/stores on a valid/ready request channel and checks alignment. Sub-word stores are done by read-modify-write against the 32-bit data memory port. Results return on a valid/ready response channel. All core-side data is little-endian; the byte order of the memory port is handled entirely inside this block.

## Interface
- No parameters; widths fixed at 32-bit address/data.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  in  1  sign-extend load result; ignored for stores and word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or reserved-size request; no memory access made.
- mem_addr  out  32  word-aligned address to data memory ({addr[31:2],2'b00}); 0 in IDLE/RESP.
- mem_wd  out  32  write word: wd[7:0] to byte a, [15:8] to a+1, [23:16] to a+2, [31:24] to a+3.
- mem_we  out  1  write strobe; memory writes on the same posedge.
- mem_rd  in  32  combinational read: byte a in [31:24], a+1 in [23:16], a+2 in [15:8], a+3 in [7:0].

## Operation
- States: IDLE, RD, WR, RESP. Request fields are registered on acceptance (req_valid && req_ready).
- IDLE: accepts a request and chooses the next state:
  - Error (half with addr[0]=1; word with addr[1:0]!=0; size 11) -> RESP with err=1.
  - Load -> RD.
  - Word store -> WR.
  - Byte/half store -> RD.
- RD: drive mem_addr. Capture the byte-swapped mem_rd as a little-endian word LW = {rd[7:0],rd[15:8],rd[23:16],rd[31:24]}.
  - Load: select the lane at addr[1:0], then zero- or sign-extend. Go to RESP.
  - Store: go to WR.
- WR: mem_we=1, mem_wd = merged word. Go to RESP.
  - Word store: mem_wd = req_wdata.
  - Sub-word store: LW with the byte lane addr[1:0] (or half lane addr[1]) replaced by req_wdata[7:0] / [15:0].
- RESP: resp_valid=1 with registered rdata/err. On resp_ready go to IDLE. No new request is accepted in the same cycle.
- Lane rules: byte lane k = LW[8k+7:8k]. Half lane = LW[15:0] when addr[1]=0, LW[31:16] when addr[1]=1.
- mem_we = (state==WR) && !rst. A reset in the WR cycle suppresses the write.

## Timing
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0.
- Acceptance at cycle T. resp_valid rises at:
  - Load: T+2.
  - Word store: T+2.
  - Sub-word store: T+3.
  - Error: T+1.
- Response stalls indefinitely while resp_ready=0; outputs stay stable.
- Throughput: one request per 3–4 cycles; no pipelining or overlap.
- Reset mid-operation aborts the transaction. No response is produced. Memory is unchanged unless the WR edge already occurred before reset.
- mem_rd is sampled only at the end of RD. It is ignored in other states.

## Structure
- lsu_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, and the byte-swap function.
- Sub-module lsu_align: combinational. Takes LW, addr[1:0], size, signed and wdata. Produces the extended load data and the merged store word. The FSM, request/response registers and mem_* drive stay in lsu.

## Test plan
- Memory bytes 0x10..0x13 = 11 22 33 84. Signed word load @0x10 -> rdata 0x84332211, resp at T+2.
- Byte loads @0x13: signed -> 0xFFFFFF84; unsigned -> 0x00000084. Signed half load @0x12 -> 0xFFFF8433.
- Byte store 0xAB @0x11, then word load @0x10 -> 0x8433AB11. Exactly one mem_we pulse, at T+2. Response at T+3.
- Half load @0x11 and word store @0x12 -> resp_err=1, rdata 0, at T+1. mem_we never asserted. Memory unchanged.
- resp_ready held low 5 cycles -> resp_valid and rdata stable, req_ready=0. Release -> IDLE the next cycle.
- rst asserted during the WR cycle of a half store -> mem_we=0 that cycle, memory unchanged, outputs at reset values next cycle.
